// File: rtl/riscv_biu_arb2.sv
// Two-master BIU arbiter: merges instruction and data request streams onto one BIU port,
// holding ownership across bursts/locked sequences and routing responses to the issuer.
module riscv_biu_arb2 #(
  parameter int XLEN     = 64,
  parameter int PLEN     = 64,
  parameter int PRIORITY = 0
) (
  input  logic            HRESETn,
  input  logic            HCLK,

  input  logic            ibiu_stb_i,
  output logic            ibiu_stb_ack_o,
  output logic            ibiu_d_ack_o,
  input  logic [PLEN-1:0] ibiu_adri_i,
  output logic [PLEN-1:0] ibiu_adro_o,
  input  logic [2:0]      ibiu_size_i,
  input  logic [2:0]      ibiu_type_i,
  input  logic [2:0]      ibiu_prot_i,
  input  logic            ibiu_lock_i,
  input  logic            ibiu_we_i,
  input  logic [XLEN-1:0] ibiu_d_i,
  output logic [XLEN-1:0] ibiu_q_o,
  output logic            ibiu_ack_o,
  output logic            ibiu_err_o,

  input  logic            dbiu_stb_i,
  output logic            dbiu_stb_ack_o,
  output logic            dbiu_d_ack_o,
  input  logic [PLEN-1:0] dbiu_adri_i,
  output logic [PLEN-1:0] dbiu_adro_o,
  input  logic [2:0]      dbiu_size_i,
  input  logic [2:0]      dbiu_type_i,
  input  logic [2:0]      dbiu_prot_i,
  input  logic            dbiu_lock_i,
  input  logic            dbiu_we_i,
  input  logic [XLEN-1:0] dbiu_d_i,
  output logic [XLEN-1:0] dbiu_q_o,
  output logic            dbiu_ack_o,
  output logic            dbiu_err_o,

  output logic            biu_stb_o,
  output logic [PLEN-1:0] biu_adri_o,
  output logic [2:0]      biu_size_o,
  output logic [2:0]      biu_type_o,
  output logic [2:0]      biu_prot_o,
  output logic            biu_lock_o,
  output logic            biu_we_o,
  output logic [XLEN-1:0] biu_d_o,
  input  logic            biu_stb_ack_i,
  input  logic            biu_d_ack_i,
  input  logic [PLEN-1:0] biu_adro_i,
  input  logic [XLEN-1:0] biu_q_i,
  input  logic            biu_ack_i,
  input  logic            biu_err_i
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_I    = 2'b01,
    GNT_D    = 2'b10
  } gnt_t;

  gnt_t       gnt_q, gnt_d, last_gnt_q, last_gnt_d, winner;
  logic [5:0] out_cnt_q, out_cnt_d;
  logic [6:0] cnt_sum;
  logic [4:0] burst_len;
  logic       own_stb, own_lock, oth_stb, arb_en;

  // Beats per accepted request; reserved/unknown encodings count as a single beat.
  function automatic logic [4:0] type2len(input logic [2:0] t);
    case (t)
      3'b010, 3'b011: return 5'd4;
      3'b100, 3'b101: return 5'd8;
      3'b110, 3'b111: return 5'd16;
      default:        return 5'd1;
    endcase
  endfunction

  always_comb begin
    biu_stb_o  = 1'b0;
    biu_adri_o = '0;
    biu_size_o = '0;
    biu_type_o = '0;
    biu_prot_o = '0;
    biu_lock_o = 1'b0;
    biu_we_o   = 1'b0;
    biu_d_o    = '0;
    own_stb    = 1'b0;
    own_lock   = 1'b0;
    oth_stb    = 1'b0;
    case (gnt_q)
      GNT_I: begin
        biu_stb_o  = ibiu_stb_i;
        biu_adri_o = ibiu_adri_i;
        biu_size_o = ibiu_size_i;
        biu_type_o = ibiu_type_i;
        biu_prot_o = ibiu_prot_i;
        biu_lock_o = ibiu_lock_i;
        biu_we_o   = ibiu_we_i;
        biu_d_o    = ibiu_d_i;
        own_stb    = ibiu_stb_i;
        own_lock   = ibiu_lock_i;
        oth_stb    = dbiu_stb_i;
      end
      GNT_D: begin
        biu_stb_o  = dbiu_stb_i;
        biu_adri_o = dbiu_adri_i;
        biu_size_o = dbiu_size_i;
        biu_type_o = dbiu_type_i;
        biu_prot_o = dbiu_prot_i;
        biu_lock_o = dbiu_lock_i;
        biu_we_o   = dbiu_we_i;
        biu_d_o    = dbiu_d_i;
        own_stb    = dbiu_stb_i;
        own_lock   = dbiu_lock_i;
        oth_stb    = ibiu_stb_i;
      end
      default: ;
    endcase
  end

  assign ibiu_stb_ack_o = (gnt_q == GNT_I) & biu_stb_ack_i;
  assign ibiu_d_ack_o   = (gnt_q == GNT_I) & biu_d_ack_i;
  assign ibiu_ack_o     = (gnt_q == GNT_I) & biu_ack_i;
  assign ibiu_err_o     = (gnt_q == GNT_I) & biu_err_i;
  assign dbiu_stb_ack_o = (gnt_q == GNT_D) & biu_stb_ack_i;
  assign dbiu_d_ack_o   = (gnt_q == GNT_D) & biu_d_ack_i;
  assign dbiu_ack_o     = (gnt_q == GNT_D) & biu_ack_i;
  assign dbiu_err_o     = (gnt_q == GNT_D) & biu_err_i;
  assign ibiu_q_o       = biu_q_i;
  assign dbiu_q_o       = biu_q_i;
  assign ibiu_adro_o    = biu_adro_i;
  assign dbiu_adro_o    = biu_adro_i;

  // Acks with no owner (e.g. stragglers after reset) must not underflow the count.
  always_comb begin
    burst_len = type2len(biu_type_o);
    cnt_sum   = {1'b0, out_cnt_q};
    if (biu_stb_ack_i && (gnt_q != GNT_NONE)) cnt_sum = cnt_sum + {2'b00, burst_len};
    if (biu_ack_i && (cnt_sum != 7'd0))       cnt_sum = cnt_sum - 7'd1;
    out_cnt_d = biu_err_i ? 6'd0 : cnt_sum[5:0];
  end

  // Decide on the post-update count so a request accepted this cycle is never abandoned.
  always_comb begin
    arb_en = (gnt_q == GNT_NONE) ||
             ((out_cnt_d == 6'd0) && !own_lock && (!own_stb || oth_stb));
    winner = GNT_NONE;
    if (ibiu_stb_i && dbiu_stb_i) begin
      if (PRIORITY != 0)            winner = GNT_D;
      else if (last_gnt_q == GNT_I) winner = GNT_D;
      else                          winner = GNT_I;
    end else if (ibiu_stb_i) begin
      winner = GNT_I;
    end else if (dbiu_stb_i) begin
      winner = GNT_D;
    end
    gnt_d      = arb_en ? winner : gnt_q;
    last_gnt_d = (arb_en && (winner != GNT_NONE)) ? winner : last_gnt_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_q      <= GNT_NONE;
      last_gnt_q <= GNT_D;
      out_cnt_q  <= 6'd0;
    end else begin
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  a_out_cnt_max: assert property (@(posedge HCLK) disable iff (!HRESETn)
    biu_err_i || (cnt_sum <= 7'd32));

endmodule

// File: tb/tb_riscv_biu_arb2.sv
// Bench for riscv_biu_arb2: instance 0 round-robin, instance 1 fixed priority; a simple
// bridge model answers requests and a queue holds the expected owner of each beat.
`timescale 1ns/1ps
module tb_riscv_biu_arb2;
  localparam int XLEN = 64;
  localparam int PLEN = 64;
  localparam logic [2:0] T_SINGLE = 3'b000;
  localparam logic [2:0] T_INCR   = 3'b001;
  localparam logic [2:0] T_WRAP4  = 3'b010;
  localparam logic [2:0] T_INCR8  = 3'b101;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic            istb, dstb, ilock, dlock, iwe, dwe;
  logic [PLEN-1:0] iadr, dadr;
  logic [2:0]      isize, dsize, itype, dtype, iprot, dprot;
  logic [XLEN-1:0] idat, ddat;

  logic            stb_ack_i [2];
  logic            d_ack_i   [2];
  logic            ack_i     [2];
  logic            err_i     [2];
  logic [PLEN-1:0] adro_i    [2];
  logic [XLEN-1:0] q_i       [2];

  logic            istb_ack_o [2], dstb_ack_o [2], id_ack_o [2], dd_ack_o [2];
  logic            iack_o [2], dack_o [2], ierr_o [2], derr_o [2];
  logic            bstb_o [2], block_o [2], bwe_o [2];
  logic [PLEN-1:0] iadro_o [2], dadro_o [2], badri_o [2];
  logic [XLEN-1:0] iq_o [2], dq_o [2], bd_o [2];
  logic [2:0]      bsize_o [2], btype_o [2], bprot_o [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    riscv_biu_arb2 #(.XLEN(XLEN), .PLEN(PLEN), .PRIORITY(g)) u_dut (
      .HRESETn(HRESETn), .HCLK(HCLK),
      .ibiu_stb_i(istb), .ibiu_stb_ack_o(istb_ack_o[g]), .ibiu_d_ack_o(id_ack_o[g]),
      .ibiu_adri_i(iadr), .ibiu_adro_o(iadro_o[g]), .ibiu_size_i(isize),
      .ibiu_type_i(itype), .ibiu_prot_i(iprot), .ibiu_lock_i(ilock), .ibiu_we_i(iwe),
      .ibiu_d_i(idat), .ibiu_q_o(iq_o[g]), .ibiu_ack_o(iack_o[g]), .ibiu_err_o(ierr_o[g]),
      .dbiu_stb_i(dstb), .dbiu_stb_ack_o(dstb_ack_o[g]), .dbiu_d_ack_o(dd_ack_o[g]),
      .dbiu_adri_i(dadr), .dbiu_adro_o(dadro_o[g]), .dbiu_size_i(dsize),
      .dbiu_type_i(dtype), .dbiu_prot_i(dprot), .dbiu_lock_i(dlock), .dbiu_we_i(dwe),
      .dbiu_d_i(ddat), .dbiu_q_o(dq_o[g]), .dbiu_ack_o(dack_o[g]), .dbiu_err_o(derr_o[g]),
      .biu_stb_o(bstb_o[g]), .biu_adri_o(badri_o[g]), .biu_size_o(bsize_o[g]),
      .biu_type_o(btype_o[g]), .biu_prot_o(bprot_o[g]), .biu_lock_o(block_o[g]),
      .biu_we_o(bwe_o[g]), .biu_d_o(bd_o[g]),
      .biu_stb_ack_i(stb_ack_i[g]), .biu_d_ack_i(d_ack_i[g]), .biu_adro_i(adro_i[g]),
      .biu_q_i(q_i[g]), .biu_ack_i(ack_i[g]), .biu_err_i(err_i[g])
    );
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned sb [$];
  int          i_left, d_left, i_start;
  logic        d_lockmode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  function automatic int blen(input logic [2:0] t);
    case (t)
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      3'b110, 3'b111: return 16;
      default:        return 1;
    endcase
  endfunction

  task automatic idle_inputs();
    istb = 0; dstb = 0; ilock = 0; dlock = 0; iwe = 0; dwe = 0;
    iadr = 64'h0000_1000; dadr = 64'h8000_2000;
    isize = 3'd3; dsize = 3'd3; itype = T_SINGLE; dtype = T_SINGLE; iprot = 3'd4; dprot = 3'd1;
    idat = 64'h1111_0000_0000_1111; ddat = 64'hDDDD_0000_0000_DDDD;
    for (int k = 0; k < 2; k++) begin
      stb_ack_i[k] = 0; d_ack_i[k] = 0; ack_i[k] = 0; err_i[k] = 0;
      adro_i[k] = 64'h0; q_i[k] = 64'h0;
    end
  endtask

  task automatic do_reset();
    HRESETn = 0;
    idle_inputs();
    repeat (2) step();
    HRESETn = 1;
    step();
  endtask

  // Masters request until their burst budgets are spent; the bridge accepts one burst
  // at a time and returns one beat per cycle afterwards.
  task automatic run(input int sel, input int budget);
    int bl = 0;
    int cyc = 0;
    int unsigned exp;
    while ((sb.size() > 0 || bl > 0) && cyc < budget) begin
      istb  = (i_left > 0) && (cyc >= i_start);
      dstb  = (d_left > 0);
      dlock = d_lockmode && (d_left > 0);
      dwe   = (d_left == 1);
      #1;
      stb_ack_i[sel] = 0;
      ack_i[sel]     = 0;
      if (bl > 0) begin
        ack_i[sel] = 1;
        q_i[sel]   = {32'hC0DE_0000, 32'(cyc)};
        bl--;
      end else if (bstb_o[sel]) begin
        stb_ack_i[sel] = 1;
        bl = blen(btype_o[sel]);
      end
      @(negedge HCLK);
      if (stb_ack_i[sel]) begin
        exp = (sb.size() > 0) ? sb[0] : 0;
        chk("grant_owner", 64'({dstb_ack_o[sel], istb_ack_o[sel]}), 64'(exp));
        chk("lock_mux", 64'(block_o[sel]), 64'((exp == 2) ? dlock : ilock));
        chk("we_mux", 64'(bwe_o[sel]), 64'((exp == 2) ? dwe : iwe));
      end
      if (ack_i[sel]) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 0;
        chk("beat_owner", 64'({dack_o[sel], iack_o[sel]}), 64'(exp));
        chk("q_bcast", (exp == 1) ? iq_o[sel] : dq_o[sel], q_i[sel]);
      end
      if (istb_ack_o[sel]) i_left--;
      if (dstb_ack_o[sel]) d_left--;
      step();
      cyc++;
    end
    stb_ack_i[sel] = 0; ack_i[sel] = 0;
    istb = 0; dstb = 0; dlock = 0; dwe = 0;
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    idle_inputs();
    d_lockmode = 0; i_left = 0; d_left = 0; i_start = 0;
    // Reset state, with a stray bridge ack present
    repeat (2) step();
    ack_i[0] = 1; stb_ack_i[0] = 1;
    #1;
    chk("rst_gnt", 64'(g_dut[0].u_dut.gnt_q), 64'd0);
    chk("rst_last_gnt", 64'(g_dut[0].u_dut.last_gnt_q), 64'd2);
    chk("rst_out_cnt", 64'(g_dut[0].u_dut.out_cnt_q), 64'd0);
    chk("rst_stb", 64'(bstb_o[0]), 64'd0);
    chk("rst_acks", 64'({iack_o[0], dack_o[0], istb_ack_o[0], dstb_ack_o[0]}), 64'd0);
    do_reset();

    // I single read
    istb = 1; itype = T_SINGLE;
    #1;
    chk("arb_latency", 64'(bstb_o[0]), 64'd0);
    step();
    chk("single_stb", 64'(bstb_o[0]), 64'd1);
    chk("single_adr", badri_o[0], iadr);
    stb_ack_i[0] = 1;
    #1;
    chk("single_stb_ack", 64'({dstb_ack_o[0], istb_ack_o[0]}), 64'd1);
    step();
    stb_ack_i[0] = 0; istb = 0;
    chk("single_cnt1", 64'(g_dut[0].u_dut.out_cnt_q), 64'd1);
    ack_i[0] = 1; q_i[0] = 64'hFEED_BEEF_0123_4567; adro_i[0] = 64'h0000_1000;
    #1;
    chk("single_ack", 64'({dack_o[0], iack_o[0]}), 64'd1);
    chk("single_q_d", dq_o[0], 64'hFEED_BEEF_0123_4567);
    chk("single_adro_d", dadro_o[0], 64'h0000_1000);
    step();
    ack_i[0] = 0;
    #1;
    chk("single_cnt0", 64'(g_dut[0].u_dut.out_cnt_q), 64'd0);
    chk("single_release", 64'(bstb_o[0]), 64'd0);

    // Both request WRAP4: I first (last grant is D), then D
    do_reset();
    itype = T_WRAP4; dtype = T_WRAP4;
    i_left = 1; d_left = 1; i_start = 0;
    sb = {1, 1, 1, 1, 2, 2, 2, 2};
    run(0, 60);

    // Round-robin alternation with INCR bursts
    do_reset();
    itype = T_INCR; dtype = T_INCR;
    i_left = 2; d_left = 2;
    sb = {1, 2, 1, 2};
    run(0, 60);

    // Fixed priority: D streaming keeps I waiting
    do_reset();
    itype = T_INCR; dtype = T_INCR;
    i_left = 1; d_left = 4;
    sb = {2, 2, 2, 2, 1};
    run(1, 60);

    // Locked D read then write, I waiting throughout
    do_reset();
    itype = T_SINGLE; dtype = T_SINGLE;
    d_lockmode = 1; i_left = 1; d_left = 2; i_start = 2;
    sb = {2, 2, 1};
    run(0, 60);
    d_lockmode = 0; i_start = 0;

    // D INCR8 aborted by error on beat 3
    do_reset();
    dtype = T_INCR8; dstb = 1;
    step();
    chk("err_gnt_d", 64'(bstb_o[0]), 64'd1);
    stb_ack_i[0] = 1;
    #1;
    chk("err_stb_ack", 64'({dstb_ack_o[0], istb_ack_o[0]}), 64'd2);
    step();
    stb_ack_i[0] = 0; dstb = 0; istb = 1; itype = T_SINGLE; ack_i[0] = 1;
    step();
    step();
    ack_i[0] = 0; err_i[0] = 1;
    #1;
    chk("err_cnt_before", 64'(g_dut[0].u_dut.out_cnt_q), 64'd6);
    chk("err_route", 64'({derr_o[0], ierr_o[0]}), 64'd2);
    step();
    err_i[0] = 0;
    #1;
    chk("err_cnt_zero", 64'(g_dut[0].u_dut.out_cnt_q), 64'd0);
    chk("err_pulse", 64'(derr_o[0]), 64'd0);
    chk("err_regrant_i", 64'(g_dut[0].u_dut.gnt_q), 64'd1);
    chk("err_regrant_adr", badri_o[0], iadr);

    // Asynchronous reset mid-burst
    do_reset();
    dtype = T_INCR8; dstb = 1;
    step();
    stb_ack_i[0] = 1;
    step();
    stb_ack_i[0] = 0; dstb = 0; ack_i[0] = 1;
    repeat (3) step();
    chk("rst_mid_cnt5", 64'(g_dut[0].u_dut.out_cnt_q), 64'd5);
    HRESETn = 0;
    #1;
    chk("rst_mid_gnt", 64'(g_dut[0].u_dut.gnt_q), 64'd0);
    chk("rst_mid_cnt", 64'(g_dut[0].u_dut.out_cnt_q), 64'd0);
    chk("rst_mid_acks", 64'({dack_o[0], iack_o[0], bstb_o[0]}), 64'd0);
    step();
    HRESETn = 1;
    step();
    chk("post_rst_ack", 64'({dack_o[0], iack_o[0]}), 64'd0);
    step();
    chk("post_rst_cnt", 64'(g_dut[0].u_dut.out_cnt_q), 64'd0);
    ack_i[0] = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
